// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the pwm_ctrl rotation path: FSM encodings,
// direction constants and default duty limits.
package pwm_ctrl_pkg;

    localparam int unsigned ANGLE_W = 12;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRequest  = 3'd1,
        StWaitCalc = 3'd2,
        StAdjust   = 3'd3,
        StDone     = 3'd4
    } ramp_state_e;

    // Shared with the delta calculator.
    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    localparam int unsigned DEF_DUTY_W       = 8;
    localparam int unsigned DEF_MIN_DUTY     = 20;
    localparam int unsigned DEF_MAX_DUTY     = 200;
    localparam int unsigned DEF_RAMP_STEP    = 4;
    localparam int unsigned DEF_SLOW_SHIFT   = 8;
    localparam int unsigned DEF_SETTLE_COUNT = 3;
    localparam int unsigned DEF_CALC_TIMEOUT = 32;
    localparam logic [ANGLE_W-1:0] DEF_TOLERANCE = 12'd8;

endpackage

// File: rtl/duty_profile.sv
// Saturating proportional map from angular error to target duty.
module duty_profile
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned        DUTY_W     = DEF_DUTY_W,
    parameter logic [ANGLE_W-1:0] TOLERANCE  = DEF_TOLERANCE,
    parameter int unsigned        MIN_DUTY   = DEF_MIN_DUTY,
    parameter int unsigned        MAX_DUTY   = DEF_MAX_DUTY,
    parameter int unsigned        SLOW_SHIFT = DEF_SLOW_SHIFT
) (
    input  logic [ANGLE_W-1:0] delta_i,
    output logic [DUTY_W-1:0]  tgt_o
);

    localparam logic [19:0] Span    = 20'(MAX_DUTY - MIN_DUTY);
    localparam logic [19:0] Zone    = 20'(1 << SLOW_SHIFT);
    localparam logic [19:0] MinWide = 20'(MIN_DUTY);

    logic [19:0] delta_ext;
    logic [19:0] prod;
    logic [19:0] scaled;
    logic [19:0] sum;

    always_comb begin
        delta_ext = 20'(delta_i);
        // Span fits 8 bits and delta 12 bits, so the product cannot exceed 20 bits.
        prod      = Span * delta_ext;
        scaled    = prod >> SLOW_SHIFT;
        sum       = MinWide + scaled;
        if (delta_i <= TOLERANCE) begin
            tgt_o = '0;
        end else if (delta_ext >= Zone) begin
            tgt_o = DUTY_W'(MAX_DUTY);
        end else begin
            tgt_o = DUTY_W'(sum);
        end
    end

endmodule

// File: rtl/rotation_ramp_ctrl.sv
// Swerve rotation controller: requests delta calculations and ramps the
// PWM duty/direction toward the target, signalling done once settled.
module rotation_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned        DUTY_W       = DEF_DUTY_W,
    parameter logic [ANGLE_W-1:0] TOLERANCE    = DEF_TOLERANCE,
    parameter int unsigned        MIN_DUTY     = DEF_MIN_DUTY,
    parameter int unsigned        MAX_DUTY     = DEF_MAX_DUTY,
    parameter int unsigned        RAMP_STEP    = DEF_RAMP_STEP,
    parameter int unsigned        SLOW_SHIFT   = DEF_SLOW_SHIFT,
    parameter int unsigned        SETTLE_COUNT = DEF_SETTLE_COUNT,
    parameter int unsigned        CALC_TIMEOUT = DEF_CALC_TIMEOUT
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [ANGLE_W-1:0] delta_angle_i,
    input  logic               dir_shortest_i,
    input  logic               calc_updated_i,
    output logic               enable_calc_o,
    output logic [DUTY_W-1:0]  pwm_duty_o,
    output logic               pwm_dir_o,
    output logic               pwm_enable_o,
    output logic               busy_o,
    output logic               rotation_done_o,
    output logic               fault_o
);

    localparam int unsigned TimeoutW = $clog2(CALC_TIMEOUT + 1);
    localparam int unsigned SettleW  = $clog2(SETTLE_COUNT + 1);

    localparam logic [TimeoutW-1:0] TimeoutLimit = TimeoutW'(CALC_TIMEOUT);
    localparam logic [SettleW-1:0]  SettleTarget = SettleW'(SETTLE_COUNT);
    localparam logic [DUTY_W-1:0]   RampStep     = DUTY_W'(RAMP_STEP);

    ramp_state_e         state_q, state_d;
    logic                enable_calc_q, enable_calc_d;
    logic [DUTY_W-1:0]   pwm_duty_q, pwm_duty_d;
    logic                pwm_dir_q, pwm_dir_d;
    logic                pwm_enable_q, pwm_enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [ANGLE_W-1:0]  delta_q, delta_d;
    logic                dir_lat_q, dir_lat_d;
    logic [TimeoutW-1:0] timeout_q, timeout_d;
    logic [SettleW-1:0]  settle_q, settle_d;

    logic [DUTY_W-1:0]   tgt;
    logic [DUTY_W-1:0]   gap;
    logic [DUTY_W-1:0]   adj_duty;
    logic                adj_dir;
    logic [SettleW-1:0]  adj_settle;
    logic                in_tol;

    duty_profile #(
        .DUTY_W    (DUTY_W),
        .TOLERANCE (TOLERANCE),
        .MIN_DUTY  (MIN_DUTY),
        .MAX_DUTY  (MAX_DUTY),
        .SLOW_SHIFT(SLOW_SHIFT)
    ) u_duty_profile (
        .delta_i(delta_q),
        .tgt_o  (tgt)
    );

    assign in_tol = (delta_q <= TOLERANCE);

    // One calculation round's duty/direction/settle update.
    always_comb begin
        adj_duty = pwm_duty_q;
        adj_dir  = pwm_dir_q;
        gap      = '0;
        if (dir_lat_q != pwm_dir_q) begin
            // Spin down before reversing; flip only once stopped.
            if (pwm_duty_q > RampStep) begin
                adj_duty = pwm_duty_q - RampStep;
            end else begin
                adj_duty = '0;
            end
            if (pwm_duty_q == '0) begin
                adj_dir = dir_lat_q;
            end
        end else if (tgt > pwm_duty_q) begin
            gap      = tgt - pwm_duty_q;
            adj_duty = (gap > RampStep) ? pwm_duty_q + RampStep : tgt;
        end else begin
            gap      = pwm_duty_q - tgt;
            adj_duty = (gap > RampStep) ? pwm_duty_q - RampStep : tgt;
        end

        if (!in_tol) begin
            adj_settle = '0;
        end else if (settle_q < SettleTarget) begin
            adj_settle = settle_q + 1'b1;
        end else begin
            adj_settle = settle_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        enable_calc_d = 1'b0;
        pwm_duty_d    = pwm_duty_q;
        pwm_dir_d     = pwm_dir_q;
        pwm_enable_d  = pwm_enable_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        fault_d       = fault_q;
        delta_d       = delta_q;
        dir_lat_d     = dir_lat_q;
        timeout_d     = timeout_q;
        settle_d      = settle_q;

        unique case (state_q)
            StIdle: begin
                pwm_duty_d = '0;
                pwm_dir_d  = DIR_CW;
                if (start_i && !abort_i) begin
                    fault_d       = 1'b0;
                    busy_d        = 1'b1;
                    pwm_enable_d  = 1'b1;
                    enable_calc_d = 1'b1;
                    settle_d      = '0;
                    state_d       = StRequest;
                end
            end
            StRequest: begin
                timeout_d = '0;
                state_d   = StWaitCalc;
            end
            StWaitCalc: begin
                if (calc_updated_i) begin
                    delta_d   = delta_angle_i;
                    dir_lat_d = dir_shortest_i;
                    state_d   = StAdjust;
                end else if (timeout_q == TimeoutLimit - 1'b1) begin
                    timeout_d    = TimeoutLimit;
                    fault_d      = 1'b1;
                    pwm_duty_d   = '0;
                    pwm_dir_d    = DIR_CW;
                    pwm_enable_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            StAdjust: begin
                pwm_duty_d = adj_duty;
                pwm_dir_d  = adj_dir;
                settle_d   = adj_settle;
                if (adj_settle >= SettleTarget && adj_duty == '0) begin
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    pwm_enable_d = 1'b0;
                    pwm_dir_d    = DIR_CW;
                    state_d      = StDone;
                end else begin
                    enable_calc_d = 1'b1;
                    state_d       = StRequest;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_i && state_q != StIdle) begin
            state_d       = StIdle;
            enable_calc_d = 1'b0;
            pwm_duty_d    = '0;
            pwm_dir_d     = DIR_CW;
            pwm_enable_d  = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            fault_d       = fault_q;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            enable_calc_q <= 1'b0;
            pwm_duty_q    <= '0;
            pwm_dir_q     <= DIR_CW;
            pwm_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            delta_q       <= '0;
            dir_lat_q     <= DIR_CW;
            timeout_q     <= '0;
            settle_q      <= '0;
        end else begin
            state_q       <= state_d;
            enable_calc_q <= enable_calc_d;
            pwm_duty_q    <= pwm_duty_d;
            pwm_dir_q     <= pwm_dir_d;
            pwm_enable_q  <= pwm_enable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            delta_q       <= delta_d;
            dir_lat_q     <= dir_lat_d;
            timeout_q     <= timeout_d;
            settle_q      <= settle_d;
        end
    end

    assign enable_calc_o   = enable_calc_q;
    assign pwm_duty_o      = pwm_duty_q;
    assign pwm_dir_o       = pwm_dir_q;
    assign pwm_enable_o    = pwm_enable_q;
    assign busy_o          = busy_q;
    assign rotation_done_o = done_q;
    assign fault_o         = fault_q;

endmodule

// File: tb/tb_rotation_ramp_ctrl.sv
// Self-checking bench for rotation_ramp_ctrl: round table, directed corner
// sequences and randomized rotations against a round-level model.
module tb_rotation_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] delta = '0;
    logic        dir_sh = 1'b0;
    logic        calc_upd = 1'b0;
    logic        enable_calc;
    logic [7:0]  pwm_duty;
    logic        pwm_dir;
    logic        pwm_enable;
    logic        busy;
    logic        rot_done;
    logic        fault;

    int checks = 0;
    int failures = 0;

    // Round-level model state.
    int m_duty, m_dir, m_settle;

    rotation_ramp_ctrl dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .start_i        (start),
        .abort_i        (abort),
        .delta_angle_i  (delta),
        .dir_shortest_i (dir_sh),
        .calc_updated_i (calc_upd),
        .enable_calc_o  (enable_calc),
        .pwm_duty_o     (pwm_duty),
        .pwm_dir_o      (pwm_dir),
        .pwm_enable_o   (pwm_enable),
        .busy_o         (busy),
        .rotation_done_o(rot_done),
        .fault_o        (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        bit          dir;
        int          exp_duty;
        int          exp_dir;
        bit          exp_done;
    } row_t;

    row_t rows[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tgt_of(input int d);
        if (d <= 8) return 0;
        if (d >= 256) return 200;
        return 20 + (180 * d) / 256;
    endfunction

    task automatic model_round(input int d, input int dir, output int done);
        int t;
        t = tgt_of(d);
        if (dir != m_dir) begin
            if (m_duty > 0) m_duty = (m_duty > 4) ? m_duty - 4 : 0;
            else m_dir = dir;
        end else if (t > m_duty) begin
            m_duty = (t - m_duty > 4) ? m_duty + 4 : t;
        end else begin
            m_duty = (m_duty - t > 4) ? m_duty - 4 : t;
        end
        m_settle = (d <= 8) ? ((m_settle < 3) ? m_settle + 1 : 3) : 0;
        done = (m_settle >= 3 && m_duty == 0) ? 1 : 0;
    endtask

    task automatic start_rot();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_enable", pwm_enable, 1);
        check("start_fault_clr", fault, 0);
        m_duty = 0;
        m_dir = 0;
        m_settle = 0;
    endtask

    // Called with the DUT in its request cycle; plays the calculator for one round.
    task automatic do_round(input logic [11:0] d, input bit dir, input int lat, input bit noise,
                            output int duty, output int pdir, output int done);
        check("enable_calc_req", enable_calc, 1);
        if (noise) start = 1'b1;
        tick();
        start = 1'b0;
        check("enable_calc_pulse", enable_calc, 0);
        repeat (lat) tick();
        calc_upd = 1'b1;
        delta = d;
        dir_sh = dir;
        tick();
        // A held calc_updated during the adjust cycle must be ignored.
        calc_upd = noise;
        delta = 12'($urandom_range(0, 4095));
        dir_sh = ~dir;
        tick();
        calc_upd = 1'b0;
        duty = pwm_duty;
        pdir = pwm_dir;
        done = rot_done;
        if (done != 0) begin
            check("done_busy", busy, 0);
            check("done_enable", pwm_enable, 0);
            tick();
            check("done_one_cycle", rot_done, 0);
        end else begin
            check("round_busy", busy, 1);
            check("round_enable", pwm_enable, 1);
        end
    endtask

    task automatic model_checked_round(input int d, input int dir, input int lat, input bit noise,
                                       output int done);
        int duty, pdir, ddone, edone;
        model_round(d, dir, edone);
        do_round(12'(d), dir[0], lat, noise, duty, pdir, ddone);
        check("model_done", ddone, edone);
        check("model_duty", duty, m_duty);
        if (edone == 0) check("model_dir", pdir, m_dir);
        done = ddone;
    endtask

    initial begin
        int duty, pdir, done, n;

        rows[0]  = '{12'd1000, 1'b0, 4,  0, 1'b0};
        rows[1]  = '{12'd256,  1'b0, 8,  0, 1'b0};
        rows[2]  = '{12'd12,   1'b0, 12, 0, 1'b0};
        rows[3]  = '{12'd20,   1'b0, 16, 0, 1'b0};
        rows[4]  = '{12'd9,    1'b0, 20, 0, 1'b0};
        rows[5]  = '{12'd9,    1'b0, 24, 0, 1'b0};
        rows[6]  = '{12'd9,    1'b0, 26, 0, 1'b0};
        rows[7]  = '{12'd9,    1'b0, 26, 0, 1'b0};
        rows[8]  = '{12'd255,  1'b0, 30, 0, 1'b0};
        rows[9]  = '{12'd2000, 1'b1, 26, 0, 1'b0};
        rows[10] = '{12'd8,    1'b1, 22, 0, 1'b0};
        rows[11] = '{12'd8,    1'b0, 18, 0, 1'b0};
        rows[12] = '{12'd9,    1'b0, 22, 0, 1'b0};
        rows[13] = '{12'd3,    1'b0, 18, 0, 1'b0};
        rows[14] = '{12'd3,    1'b0, 14, 0, 1'b0};
        rows[15] = '{12'd3,    1'b0, 10, 0, 1'b0};
        rows[16] = '{12'd3,    1'b0, 6,  0, 1'b0};
        rows[17] = '{12'd3,    1'b0, 2,  0, 1'b0};
        rows[18] = '{12'd3,    1'b0, 0,  0, 1'b1};

        #12;
        check("rst_duty", pwm_duty, 0);
        check("rst_enable_calc", enable_calc, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_done", rot_done, 0);
        check("rst_pwm_en", pwm_enable, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Round table from a fresh rotation.
        start_rot();
        for (int i = 0; i < 19; i++) begin
            do_round(rows[i].d, rows[i].dir, i % 5, 1'b0, duty, pdir, done);
            check($sformatf("row%0d_done", i), done, int'(rows[i].exp_done));
            check($sformatf("row%0d_duty", i), duty, rows[i].exp_duty);
            if (!rows[i].exp_done) check($sformatf("row%0d_dir", i), pdir, rows[i].exp_dir);
        end
        tick();
        check("idle_after_done", busy, 0);

        // Ramp to the ceiling, then down into the proportional zone.
        start_rot();
        for (int i = 0; i < 52; i++) model_checked_round(1000, 0, 5, 1'b0, done);
        check("ceiling_duty", pwm_duty, 200);
        for (int i = 0; i < 25; i++) model_checked_round(128, 0, 5, 1'b0, done);
        check("prop_duty", pwm_duty, 110);
        // Abort together with start in the wait cycle.
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_duty", pwm_duty, 0);
        check("abort_busy", busy, 0);
        check("abort_enable", pwm_enable, 0);
        check("abort_done", rot_done, 0);
        tick();
        check("abort_start_lost", busy, 0);
        check("abort_no_done", rot_done, 0);
        check("abort_no_req", enable_calc, 0);
        check("abort_fault", fault, 0);

        // Asynchronous reset mid-ramp at duty 60.
        start_rot();
        for (int i = 0; i < 15; i++) model_checked_round(1000, 0, 6, 1'b0, done);
        check("pre_reset_duty", pwm_duty, 60);
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_duty", pwm_duty, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_enable", pwm_enable, 0);
        check("async_rst_done", rot_done, 0);
        #2;
        rst = 1'b0;
        tick();

        // Calculator never answers.
        start_rot();
        n = 0;
        while (!fault && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 33);
        check("timeout_fault", fault, 1);
        check("timeout_duty", pwm_duty, 0);
        check("timeout_enable", pwm_enable, 0);
        check("timeout_busy", busy, 0);
        tick();
        start_rot();
        check("fault_cleared", fault, 0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("post_fault_abort", busy, 0);
        tick();

        // Randomized rotations.
        for (int r = 0; r < 6; r++) begin
            start_rot();
            done = 0;
            for (int i = 0; i < 40 && done == 0; i++) begin
                int d, dir;
                case ($urandom_range(0, 3))
                    0: d = $urandom_range(256, 4095);
                    1: d = $urandom_range(9, 255);
                    2: d = $urandom_range(0, 8);
                    default: d = $urandom_range(200, 300);
                endcase
                dir = ($urandom_range(0, 9) < 8) ? m_dir : 1 - m_dir;
                model_checked_round(d, dir, $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                                    done);
            end
            for (int i = 0; i < 200 && done == 0; i++) begin
                model_checked_round($urandom_range(0, 8), m_dir, $urandom_range(0, 10),
                                    1'($urandom_range(0, 1)), done);
            end
            check("rand_finished", done, 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rotation_ramp_ctrl.md
Name: rotation_ramp_ctrl

Overview:
- Consumer and initiator of the steering-angle delta handshake. Issues enable_calc requests, receives the resulting delta_angle, dir_shortest and calc_updated, and converts them into a ramped PWM duty and direction for the swerve rotation motor.
- Sits between the delta calculator and the PWM generator in pwm_ctrl.
- Ends a rotation with a done pulse once the wheel has settled inside tolerance.

Parameters:
- DUTY_W, 8, width of the duty command.
- TOLERANCE, 12'd8, delta at or below this counts as on-target.
- MIN_DUTY, 8'd20, duty floor while approaching the target.
- MAX_DUTY, 8'd200, duty ceiling.
- RAMP_STEP, 8'd4, maximum change of duty per calculation round.
- SLOW_SHIFT, 8, the proportional zone is 2^SLOW_SHIFT counts wide.
- SETTLE_COUNT, 3, number of consecutive in-tolerance rounds required before done.
- CALC_TIMEOUT, 32, cycles to wait for calc_updated before raising fault.

Ports:
- clock  in  1  main clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a rotation; ignored while busy.
- abort  in  1  immediate stop; has priority over everything except reset.
- delta_angle  in  12  shortest distance from current to target.
- dir_shortest  in  1  direction of the shortest path (1=CCW, 0=CW).
- calc_updated  in  1  one-cycle pulse meaning delta_angle and dir_shortest are valid.
- enable_calc  out  1  request for a new delta calculation.
- pwm_duty  out  DUTY_W  duty command.
- pwm_dir  out  1  motor direction.
- pwm_enable  out  1  motor drive enable.
- busy  out  1  a rotation is in progress.
- rotation_done  out  1  one-cycle pulse on successful completion.
- fault  out  1  sticky calculation-timeout flag.

Behaviour:
- Reset (async): every output is 0; state IDLE; settle and timeout counters are 0.
- States are IDLE, REQUEST, WAIT_CALC, ADJUST, DONE.
- IDLE:
  - On start: clear fault, set busy=1 and pwm_enable=1, go to REQUEST.
  - pwm_duty and pwm_dir hold 0 in IDLE.
- REQUEST:
  - enable_calc=1 for exactly this one registered cycle.
  - Timeout counter cleared. Go to WAIT_CALC.
- WAIT_CALC:
  - On calc_updated: latch delta_angle and dir_shortest, go to ADJUST.
  - Otherwise the timeout counter increments each cycle.
  - When the counter reaches CALC_TIMEOUT: set fault=1; set pwm_duty=0, pwm_enable=0, busy=0; go to IDLE.
  - calc_updated in any other state is ignored.
- ADJUST (one cycle), using the latched delta d:
  - Target duty tgt:
    - 0 if d <= TOLERANCE.
    - MAX_DUTY if d >= 2^SLOW_SHIFT.
    - Otherwise MIN_DUTY + (((MAX_DUTY-MIN_DUTY) * d) >> SLOW_SHIFT). Compute with a 20-bit intermediate, no overflow.
  - Direction reversal (dir_shortest != pwm_dir):
    - If pwm_duty > 0: pwm_duty = pwm_duty - RAMP_STEP, saturating at 0; pwm_dir unchanged.
    - If pwm_duty == 0: pwm_dir takes dir_shortest and duty stays 0 this round.
  - Same direction: move pwm_duty toward tgt by min(|tgt - duty|, RAMP_STEP). No overshoot; the result stays within 0..MAX_DUTY.
  - Settle counter:
    - Increments (saturating) when d <= TOLERANCE.
    - Clears when d > TOLERANCE.
  - If the settle counter is >= SETTLE_COUNT and the updated duty == 0, go to DONE; otherwise go to REQUEST.
- DONE (one cycle): rotation_done=1; busy=0; pwm_enable=0; go to IDLE.
- Abort in any non-IDLE state:
  - Next edge sets pwm_duty=0, pwm_enable=0, busy=0; state goes to IDLE.
  - No rotation_done pulse; fault is unchanged.
  - Abort and start in the same cycle: abort wins.
- Start while busy: ignored.
- Reset mid-rotation: outputs clear asynchronously; no done pulse.
- Round latency: REQUEST + WAIT_CALC (the calculator responds about 7 cycles after enable_calc) + ADJUST, about 9 cycles per duty update.

Decomposition:
- Shared package pwm_ctrl_pkg holds:
  - the state encodings;
  - the direction constants DIR_CW=0 and DIR_CCW=1, shared with the delta calculator;
  - the default duty limits.
- One natural sub-module, duty_profile: a pure combinational mapping of d to tgt (saturating proportional map). The ramp and state logic stay in the top level.

Test Plan:
1. start; calculator model returns d=1000, dir=0 every round -> enable_calc one cycle per round; duty 4, 8, … 200, then holds at 200; pwm_enable=1, busy=1.
2. Duty at 200, d changes to 128 -> tgt = 20 + (180*128 >> 8) = 110; duty steps 196, 192, … 112, 110, then holds 110.
3. Duty at 8, d=5 for every round -> duty 4, 0, 0; rotation_done pulses one cycle after the third in-tolerance round; pwm_enable=0; busy=0.
4. Duty at 100 with dir=0, model switches to dir=1 with d=2000 -> duty ramps 96 … 0 with pwm_dir=0; the next round sets pwm_dir=1 at duty 0; the following rounds ramp 4, 8, ….
5. Model never pulses calc_updated -> 32 cycles after REQUEST, fault=1, duty=0, pwm_enable=0; the next start clears fault.
6. abort mid-ramp at duty 60 -> next cycle duty=0, busy=0, no rotation_done. Repeat with reset asserted mid-ramp -> all outputs 0 immediately, without waiting for a clock edge.
